// File: rtl/seq_shifter_pkg.sv
// -----------------------------------------------------------------------------
// seq_shifter_pkg
//   Shared types and helpers for the iterative shifter.
//   - state_t   : controller states (IDLE, SHIFT, DONE)
//   - mode_t    : shift mode, decoded once when an operand is accepted
//   - decode_mode() : maps the left/ar/rot request bits onto mode_t
//   - eff_count()   : number of single-bit steps an operation really needs
// -----------------------------------------------------------------------------
package seq_shifter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        LSL,
        LSR,
        ASR,
        ROL,
        ROR
    } mode_t;

    // rot beats ar; ar only matters for right shifts.
    function automatic mode_t decode_mode(input logic left, input logic ar, input logic rot);
        if (rot) begin
            return left ? ROL : ROR;
        end
        if (left) begin
            return LSL;
        end
        return ar ? ASR : LSR;
    endfunction

    // Rotates wrap modulo the width; plain shifts saturate at the width,
    // since W steps already flush every original bit out.
    function automatic int unsigned eff_count(input int unsigned amt,
                                              input mode_t       mode,
                                              input int unsigned w);
        if (mode == ROL || mode == ROR) begin
            return amt % w;
        end
        return (amt > w) ? w : amt;
    endfunction

endpackage

// File: rtl/seq_shifter_step.sv
// -----------------------------------------------------------------------------
// shift_step
//   Combinational one- or two-position shift of a W-bit value.
//   Ports:
//     i_value : value to shift
//     i_mode  : shift mode (LSL, LSR, ASR, ROL, ROR)
//     i_step  : positions to move, 1 or 2
//     o_value : shifted value
// -----------------------------------------------------------------------------
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_value,
    input  mode_t        i_mode,
    input  logic [1:0]   i_step,
    output logic [W-1:0] o_value
);

    function automatic logic [W-1:0] shift1(input logic [W-1:0] v, input mode_t m);
        case (m)
            LSL:     return {v[W-2:0], 1'b0};
            ROL:     return {v[W-2:0], v[W-1]};
            LSR:     return {1'b0, v[W-1:1]};
            ASR:     return {v[W-1], v[W-1:1]};
            ROR:     return {v[0], v[W-1:1]};
            default: return v;
        endcase
    endfunction

    logic [W-1:0] w_one;
    logic [W-1:0] w_two;

    // The double step is two chained single steps, so an arithmetic shift
    // still refills from the (unchanged) sign bit on the second position.
    always_comb begin
        w_one   = shift1(i_value, i_mode);
        w_two   = shift1(w_one, i_mode);
        o_value = (i_step == 2'd2) ? w_two : w_one;
    end

endmodule

// File: rtl/seq_shifter.sv
// -----------------------------------------------------------------------------
// seq_shifter
//   Multi-cycle iterative shifter: logical/arithmetic/rotate, left or right,
//   one bit position per clock. Operands arrive on a valid/ready handshake,
//   results leave on a valid/ready handshake; one operation in flight.
//   Optional build macro SEQ_SHIFTER_DUAL_STEP_EN: move two positions per clock
//   while at least two remain (same results, about half the latency).
//   Ports:
//     clk, nrst             : rising-edge clock, async active-low reset
//     in_valid / in_ready   : operand handshake (in_ready only in IDLE)
//     data_in, amt          : operand and shift amount
//     left, ar, rot         : direction, arithmetic fill, rotate (rot wins)
//     out_valid / out_ready : result handshake (out_valid only in DONE)
//     data_out              : result, held after the result handshake
// -----------------------------------------------------------------------------
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned AMT_W = $clog2(W) + 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     data_in,
    input  logic [AMT_W-1:0] amt,
    input  logic             left,
    input  logic             ar,
    input  logic             rot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     data_out
);

    state_t           r_state;
    mode_t            r_mode;
    logic [W-1:0]     r_data;
    logic [W-1:0]     r_data_out;
    logic [AMT_W-1:0] r_cnt;

    mode_t            w_mode;
    logic [AMT_W-1:0] w_eff;
    logic [1:0]       w_step;
    logic [W-1:0]     w_shifted;

    assign w_mode = decode_mode(left, ar, rot);
    assign w_eff  = AMT_W'(eff_count(32'(amt), w_mode, W));

`ifdef SEQ_SHIFTER_DUAL_STEP_EN
    assign w_step = (r_cnt >= AMT_W'(2)) ? 2'd2 : 2'd1;
`else
    assign w_step = 2'd1;
`endif

    shift_step #(
        .W(W)
    ) u_step (
        .i_value(r_data),
        .i_mode (r_mode),
        .i_step (w_step),
        .o_value(w_shifted)
    );

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign data_out  = r_data_out;

    // data_out is a separate register loaded only on entry to DONE, so it
    // keeps showing the previous result while the next one is being shifted.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= IDLE;
            r_mode     <= LSL;
            r_data     <= '0;
            r_data_out <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data <= data_in;
                        r_mode <= w_mode;
                        r_cnt  <= w_eff;
                        if (w_eff == '0) begin
                            r_data_out <= data_in;
                            r_state    <= DONE;
                        end else begin
                            r_state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    r_data <= w_shifted;
                    r_cnt  <= r_cnt - AMT_W'(w_step);
                    if (r_cnt == AMT_W'(w_step)) begin
                        r_data_out <= w_shifted;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// -----------------------------------------------------------------------------
// tb_seq_shifter
//   Self-checking bench for seq_shifter (W=8). A behavioural model computes
//   each result with plain arithmetic and tracks when the result is due; a
//   negedge compare process checks in_ready/out_valid/data_out every cycle.
//   Directed cases pin the model and the DUT to hand-computed values.
// -----------------------------------------------------------------------------
module tb_seq_shifter;

    localparam int unsigned W     = 8;
    localparam int unsigned AMT_W = 4;

    logic             clk = 1'b0;
    logic             nrst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     data_in;
    logic [AMT_W-1:0] amt;
    logic             left;
    logic             ar;
    logic             rot;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     data_out;

    seq_shifter #(
        .W    (W),
        .AMT_W(AMT_W)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .amt      (amt),
        .left     (left),
        .ar       (ar),
        .rot      (rot),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [7:0] ref_result(input logic [7:0] d, input int unsigned a,
                                              input logic l, input logic sa, input logic ro);
        logic [15:0]       dd;
        logic signed [7:0] sd;
        int unsigned       k;
        if (ro) begin
            k  = a % W;
            dd = {d, d};
            if (l) begin
                dd = dd << k;
                return dd[15:8];
            end
            dd = dd >> k;
            return dd[7:0];
        end
        if (l) begin
            return (a >= W) ? 8'h00 : 8'(d << a);
        end
        if (sa) begin
            sd = d;
            sd = sd >>> ((a >= W) ? (W - 1) : a);
            return sd;
        end
        return (a >= W) ? 8'h00 : 8'(d >> a);
    endfunction

    function automatic int unsigned ref_latency(input int unsigned a, input logic ro);
        int unsigned e;
        e = ro ? (a % W) : ((a > W) ? W : a);
`ifdef SEQ_SHIFTER_DUAL_STEP_EN
        return (e + 1) / 2;
`else
        return e;
`endif
    endfunction

    logic        m_busy = 1'b0;
    logic [7:0]  m_exp  = 8'h00;
    logic [7:0]  m_last = 8'h00;
    int unsigned cyc    = 0;
    int unsigned m_due  = 0;

    // m_due is the edge count after which the result must be visible.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_busy <= 1'b0;
            m_last <= 8'h00;
        end else begin
            cyc <= cyc + 1;
            if (!m_busy) begin
                if (in_valid) begin
                    m_busy <= 1'b1;
                    m_exp  <= ref_result(data_in, 32'(amt), left, ar, rot);
                    m_due  <= cyc + 1 + ref_latency(32'(amt), rot);
                end
            end else if (cyc >= m_due && out_ready) begin
                m_busy <= 1'b0;
                m_last <= m_exp;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic ev;
        ev = m_busy && (cyc >= m_due);
        check("in_ready", 32'(in_ready), 32'(!m_busy));
        check("out_valid", 32'(out_valid), 32'(ev));
        if (!m_busy) begin
            check("data_out_idle", 32'(data_out), 32'(m_last));
        end else if (ev) begin
            check("data_out_result", 32'(data_out), 32'(m_exp));
        end
    end

    // ---------------- drivers ----------------
    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [7:0] d, input logic [3:0] a,
                        input logic l, input logic sa, input logic ro);
        int unsigned t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("accept_ready", 32'(in_ready), 32'(1));
        data_in  = d;
        amt      = a;
        left     = l;
        ar       = sa;
        rot      = ro;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        // Busy-time input changes must be ignored.
        data_in  = 8'($urandom);
        amt      = 4'($urandom);
        left     = 1'($urandom);
        ar       = 1'($urandom);
        rot      = 1'($urandom);
    endtask

    task automatic directed(input string nm, input logic [7:0] d, input logic [3:0] a,
                            input logic l, input logic sa, input logic ro,
                            input logic [7:0] expv, input int unsigned explat);
        int unsigned waited = 0;
        out_ready = 1'b0;
        send(d, a, l, sa, ro);
        while (!out_valid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check({nm, "_latency"}, waited, explat);
        check({nm, "_data"}, 32'(data_out), 32'(expv));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({nm, "_back_idle"}, 32'(in_ready), 32'(1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        int unsigned seen;
        int unsigned t;
        nrst      = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        amt       = '0;
        left      = 1'b0;
        ar        = 1'b0;
        rot       = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;

        check("reset_out_valid", 32'(out_valid), 32'(0));
        check("reset_data_out", 32'(data_out), 32'(0));
        check("reset_in_ready", 32'(in_ready), 32'(1));

        // Pin the model to hand-computed values.
        check("model_asr", 32'(ref_result(8'h96, 3, 1'b0, 1'b1, 1'b0)), 32'h0000_00F2);
        check("model_ror", 32'(ref_result(8'h81, 9, 1'b0, 1'b0, 1'b1)), 32'h0000_00C0);
        check("model_lsl_sat", 32'(ref_result(8'hFF, 12, 1'b1, 1'b0, 1'b0)), 32'h0000_0000);
        check("model_asr_sat", 32'(ref_result(8'h80, 15, 1'b0, 1'b1, 1'b0)), 32'h0000_00FF);
        check("model_rol", 32'(ref_result(8'h81, 3, 1'b1, 1'b0, 1'b1)), 32'h0000_000C);

`ifdef SEQ_SHIFTER_DUAL_STEP_EN
        directed("asr3",   8'h96, 4'd3,  1'b0, 1'b1, 1'b0, 8'hF2, 2);
        directed("ror9",   8'h81, 4'd9,  1'b0, 1'b0, 1'b1, 8'hC0, 1);
        directed("lsl12",  8'hFF, 4'd12, 1'b1, 1'b0, 1'b0, 8'h00, 4);
        directed("asr15",  8'h80, 4'd15, 1'b0, 1'b1, 1'b0, 8'hFF, 4);
        directed("lsl_ar", 8'hC3, 4'd2,  1'b1, 1'b1, 1'b0, 8'h0C, 1);
`else
        directed("asr3",   8'h96, 4'd3,  1'b0, 1'b1, 1'b0, 8'hF2, 3);
        directed("ror9",   8'h81, 4'd9,  1'b0, 1'b0, 1'b1, 8'hC0, 1);
        directed("lsl12",  8'hFF, 4'd12, 1'b1, 1'b0, 1'b0, 8'h00, 8);
        directed("asr15",  8'h80, 4'd15, 1'b0, 1'b1, 1'b0, 8'hFF, 8);
        directed("lsl_ar", 8'hC3, 4'd2,  1'b1, 1'b1, 1'b0, 8'h0C, 2);
`endif

        // Zero amount with backpressure, then a back-to-back accept.
        out_ready = 1'b0;
        send(8'h3C, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'(1));
            check("bp_data", 32'(data_out), 32'h0000_003C);
            check("bp_in_ready", 32'(in_ready), 32'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_ready", 32'(in_ready), 32'(1));
        check("bp_release_valid", 32'(out_valid), 32'(0));
        check("bp_release_hold", 32'(data_out), 32'h0000_003C);
        send(8'h5A, 4'd1, 1'b1, 1'b0, 1'b0);
        check("b2b_busy", 32'(in_ready), 32'(0));
        @(negedge clk);
        check("b2b_valid", 32'(out_valid), 32'(1));
        check("b2b_data", 32'(data_out), 32'h0000_00B4);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of a shift.
        send(8'hA5, 4'd5, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 nrst = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'(0));
        check("rst_mid_data", 32'(data_out), 32'(0));
        check("rst_mid_ready", 32'(in_ready), 32'(1));
        @(negedge clk);
        nrst      = 1'b1;
        out_ready = 1'b1;
        seen      = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_no_result", seen, 0);
        out_ready = 1'b0;

        // Randomised operations across all modes and amounts.
        for (int n = 0; n < 1000; n++) begin
            send(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom),
                 1'($urandom), 1'($urandom));
            t = 0;
            while (m_busy && t < 100) begin
                @(negedge clk);
                out_ready = 1'($urandom_range(0, 1));
                t++;
            end
            check("rand_drained", 32'(m_busy), 32'(0));
        end
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
